// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding-mux encoding
// and the per-stage shadow record kept for EX, MEM and WB.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       regwrite;
    logic       memread;
    logic       memacc;
  } stage_info_t;

  localparam stage_info_t STAGE_EMPTY = '0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the core pipeline (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import hazard_pkg::*;

  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_memacc;
  logic             mem_ready;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             bubble_ex;
  logic             bubble_wb;
  fwd_sel_t         fwd_a;
  fwd_sel_t         fwd_b;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_regwrite, id_memread, id_memacc, mem_ready,
    input  stall_if, stall_id, stall_ex, bubble_ex, bubble_wb,
           fwd_a, fwd_b, mem_err, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_regwrite, id_memread, id_memacc, mem_ready,
    output stall_if, stall_id, stall_ex, bubble_ex, bubble_wb,
           fwd_a, fwd_b, mem_err, stall_cycles
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX operand; MEM wins over WB, loads in MEM are
// not forwardable (their data is not ready yet) and x0 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] ex_rs_i,
  input  logic       mem_valid_i,
  input  logic       mem_regwrite_i,
  input  logic       mem_memread_i,
  input  logic [4:0] mem_rd_i,
  input  logic       wb_valid_i,
  input  logic       wb_regwrite_i,
  input  logic [4:0] wb_rd_i,
  output fwd_sel_t   sel_o
);

  always_comb begin
    sel_o = FWD_NONE;
    if (mem_valid_i && mem_regwrite_i && !mem_memread_i &&
        (mem_rd_i != 5'd0) && (mem_rd_i == ex_rs_i))
      sel_o = FWD_MEM;
    else if (wb_valid_i && wb_regwrite_i &&
             (wb_rd_i != 5'd0) && (wb_rd_i == ex_rs_i))
      sel_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows EX/MEM/WB, raises load-use and
// memory-wait stalls, selects forwarding, and tracks timeout / stall statistics.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  stage_info_t      id_info;
  stage_info_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             mem_wait, load_use, lu_stall, stall_any;
  logic             wb_unused;

  assign id_info = '{valid:    hz.id_valid,
                     rd:       hz.id_rd,
                     rs1:      hz.id_rs1,
                     rs2:      hz.id_rs2,
                     regwrite: hz.id_regwrite,
                     memread:  hz.id_memread,
                     memacc:   hz.id_memacc};

  assign mem_wait = mem_q.valid & mem_q.memacc & ~hz.mem_ready;
  assign load_use = hz.id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) &
                    ((hz.id_uses_rs1 & (hz.id_rs1 == ex_q.rd)) |
                     (hz.id_uses_rs2 & (hz.id_rs2 == ex_q.rd)));
  // A pending memory access freezes everything; load-use is re-judged once it completes.
  assign lu_stall  = load_use & ~mem_wait;
  assign stall_any = mem_wait | lu_stall;

  always_comb begin
    ex_d   = id_info;
    mem_d  = ex_q;
    wb_d   = mem_q;
    wait_d = '0;
    err_d  = err_q;
    scnt_d = scnt_q;
    if (mem_wait) begin
      ex_d   = ex_q;
      mem_d  = mem_q;
      wb_d   = STAGE_EMPTY;
      wait_d = (wait_q >= WCNT_W'(MEM_TIMEOUT)) ? wait_q : wait_q + 1'b1;
      if (wait_q >= WCNT_W'(MEM_TIMEOUT - 1))
        err_d = 1'b1;
    end else if (lu_stall) begin
      ex_d = STAGE_EMPTY;
    end
    if (stall_any && (scnt_q != '1))
      scnt_d = scnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q   <= STAGE_EMPTY;
      mem_q  <= STAGE_EMPTY;
      wb_q   <= STAGE_EMPTY;
      wait_q <= '0;
      err_q  <= 1'b0;
      scnt_q <= '0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      wait_q <= wait_d;
      err_q  <= err_d;
      scnt_q <= scnt_d;
    end
  end

  assign hz.stall_if     = stall_any;
  assign hz.stall_id     = stall_any;
  assign hz.stall_ex     = mem_wait;
  assign hz.bubble_ex    = lu_stall;
  assign hz.bubble_wb    = mem_wait;
  assign hz.mem_err      = err_q;
  assign hz.stall_cycles = scnt_q;

  // WB only needs valid/rd/regwrite; the remaining fields ride along in the shared record.
  assign wb_unused = ^{wb_q.rs1, wb_q.rs2, wb_q.memread, wb_q.memacc};

  hazard_fwd_sel u_fwd_a (
    .ex_rs_i        (ex_q.rs1),
    .mem_valid_i    (mem_q.valid),
    .mem_regwrite_i (mem_q.regwrite),
    .mem_memread_i  (mem_q.memread),
    .mem_rd_i       (mem_q.rd),
    .wb_valid_i     (wb_q.valid),
    .wb_regwrite_i  (wb_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .sel_o          (hz.fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .ex_rs_i        (ex_q.rs2),
    .mem_valid_i    (mem_q.valid),
    .mem_regwrite_i (mem_q.regwrite),
    .mem_memread_i  (mem_q.memread),
    .mem_rd_i       (mem_q.rd),
    .wb_valid_i     (wb_q.valid),
    .wb_regwrite_i  (wb_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .sel_o          (hz.fwd_b)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step drives ID/mem_ready, queues the
// expected outputs, and compares them at the following falling edge.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CNT_W       = 8;
  localparam int MEM_TIMEOUT = 64;
  localparam int SC_MAX      = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  typedef struct {
    logic             si, sid, sex, bex, bwb;
    logic [1:0]       fa, fb;
    logic             merr;
    logic [CNT_W-1:0] sc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   sc_model = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic rw, input logic mr, input logic ma);
    hz.id_valid    = v;
    hz.id_rd       = rd;
    hz.id_rs1      = rs1;
    hz.id_rs2      = rs2;
    hz.id_uses_rs1 = u1;
    hz.id_uses_rs2 = u2;
    hz.id_regwrite = rw;
    hz.id_memread  = mr;
    hz.id_memacc   = ma;
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input logic si, input logic sid, input logic sex,
                            input logic bex, input logic bwb, input logic [1:0] fa,
                            input logic [1:0] fb, input logic merr);
    exp_t e;
    e.si = si; e.sid = sid; e.sex = sex; e.bex = bex; e.bwb = bwb;
    e.fa = fa; e.fb = fb; e.merr = merr;
    e.sc = CNT_W'(sc_model);
    q.push_back(e);
    if (si && sc_model < SC_MAX) sc_model++;
  endtask

  task automatic ok(input logic merr);
    expect_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, merr);
  endtask

  task automatic wait_exp(input logic merr);
    expect_out(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, merr);
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    chk("scoreboard_depth", 32'(q.size() != 0), 32'(1));
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("stall_if",     32'(hz.stall_if),     32'(e.si));
      chk("stall_id",     32'(hz.stall_id),     32'(e.sid));
      chk("stall_ex",     32'(hz.stall_ex),     32'(e.sex));
      chk("bubble_ex",    32'(hz.bubble_ex),    32'(e.bex));
      chk("bubble_wb",    32'(hz.bubble_wb),    32'(e.bwb));
      chk("fwd_a",        32'(hz.fwd_a),        32'(e.fa));
      chk("fwd_b",        32'(hz.fwd_b),        32'(e.fb));
      chk("mem_err",      32'(hz.mem_err),      32'(e.merr));
      chk("stall_cycles", 32'(hz.stall_cycles), 32'(e.sc));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    hz.mem_ready = 1'b1;
    nop();
    @(posedge clk);
    #1;

    // Reset held with a would-be hazard on ID: everything stays zero.
    issue(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    ok(1'b0); cycle();
    rst_n = 1'b1;

    // add x5 ; sub x8,x5,x7 -> MEM forwarding on operand A
    issue(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); ok(1'b0); cycle();
    issue(1'b1, 5'd8, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); ok(1'b0); cycle();
    nop(); expect_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0); cycle();
    nop(); ok(1'b0); cycle();

    // lw x6 ; add x9,x3,x6 -> one load-use bubble, then WB forwarding on B
    issue(1'b1, 5'd6, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1); ok(1'b0); cycle();
    issue(1'b1, 5'd9, 5'd3, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0); cycle();
    ok(1'b0); cycle();
    nop(); expect_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0); cycle();

    // lw x0 ; add x0,x0,x0 -> x0 never stalls nor forwards (EX, MEM and WB)
    issue(1'b1, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1); ok(1'b0); cycle();
    issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); ok(1'b0); cycle();
    nop(); ok(1'b0); cycle();
    nop(); ok(1'b0); cycle();

    // sw reaching MEM with mem_ready low for 3 cycles
    issue(1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); ok(1'b0); cycle();
    nop(); ok(1'b0); cycle();
    hz.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin wait_exp(1'b0); cycle(); end
    hz.mem_ready = 1'b1;
    ok(1'b0); cycle();

    // Load-use coinciding with a memory wait: wait first, then the bubble
    issue(1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); ok(1'b0); cycle();
    issue(1'b1, 5'd7, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1); ok(1'b0); cycle();
    issue(1'b1, 5'd11, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    hz.mem_ready = 1'b0;
    wait_exp(1'b0); cycle();
    hz.mem_ready = 1'b1;
    expect_out(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0); cycle();
    ok(1'b0); cycle();
    nop(); expect_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0); cycle();

    // Memory timeout: mem_err rises only after the 64th wait cycle and sticks
    issue(1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); ok(1'b0); cycle();
    nop(); ok(1'b0); cycle();
    hz.mem_ready = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin wait_exp(1'b0); cycle(); end
    hz.mem_ready = 1'b1;
    ok(1'b1); cycle();
    ok(1'b1); cycle();

    // Long wait drives stall_cycles into saturation
    issue(1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); ok(1'b1); cycle();
    nop(); ok(1'b1); cycle();
    hz.mem_ready = 1'b0;
    for (int i = 0; i < 200; i++) begin wait_exp(1'b1); cycle(); end

    // Reset in the middle of that wait abandons the access
    rst_n = 1'b0;
    sc_model = 0;
    ok(1'b0); cycle();
    rst_n = 1'b1;
    ok(1'b0); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
